signed_number_32_bit_divider: RTL and testbench

- Sequential signed divider. Computes quotient and remainder of a / b, truncating toward zero.
- Uses restoring shift-subtract, one quotient bit per clock.
- Sits in the ALU next to the signed multiplier and shares the same start/done handshake, so the ALU controller drives both identically.
- Results use RISC-V M-extension semantics for divide-by-zero and overflow.

---
 rtl/alu_div_pkg.sv | 31 +++
 rtl/div_restore_step.sv | 30 +++
 rtl/signed_number_32_bit_divider.sv | 134 +++++++++++++
 tb/tb_signed_number_32_bit_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Optional div_err flag port enabled by SIGNED_DIV_ERR_FLAG_EN.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int MAXW      = 64;

  // Callers zero-extend a WIDTH-bit value into v and truncate the result.
  function automatic logic [MAXW-1:0] abs_mag(
    input logic [MAXW-1:0] v,
    input int unsigned     w
  );
    return (((v >> (w - 1)) & MAXW'(1)) != '0) ?
           (~v + 1'b1) : v;
  endfunction

  function automatic logic is_int_min(
    input logic [MAXW-1:0] v,
    input int unsigned     w
  );
    return (((v >> (w - 1)) & MAXW'(1)) != '0) &&
           ((v << (MAXW - w + 1)) == '0);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration, purely combinational.
// Optional div_err flag (SIGNED_DIV_ERR_FLAG_EN) lives in the top only.
module div_restore_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] rs;
  logic [WIDTH+1:0] t;

  assign rs = {r, q[WIDTH-1]};
  assign t  = rs - {2'b00, d};

  always_comb begin
    r_next = rs[WIDTH:0];
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!t[WIDTH+1]) begin
      r_next = t[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/signed_number_32_bit_divider.sv
// Sequential signed divider, restoring, one quotient bit per clock.
// Define SIGNED_DIV_ERR_FLAG_EN to add the div_err output.
module signed_number_32_bit_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef SIGNED_DIV_ERR_FLAG_EN
  ,
  output logic             div_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             qsign;
  logic             rsign;
  logic             dz;
  logic             ovf;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_lo;
  logic             b_zero;
  logic             a_ovf;

  assign a_mag  = WIDTH'(abs_mag(MAXW'(a), WIDTH));
  assign b_mag  = WIDTH'(abs_mag(MAXW'(b), WIDTH));
  assign b_zero = (b == '0);
  assign a_ovf  = is_int_min(MAXW'(a), WIDTH) &&
                  (b == '1);
  assign r_lo   = r[WIDTH-1:0];

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SIGNED_DIV_ERR_FLAG_EN
      div_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            q     <= a_mag;
            d     <= b_mag;
            r     <= '0;
            qsign <= a[WIDTH-1] ^ b[WIDTH-1];
            rsign <= a[WIDTH-1];
            dz    <= b_zero;
            ovf   <= a_ovf;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef SIGNED_DIV_ERR_FLAG_EN
            div_err <= 1'b0;
`endif
            state <= (b_zero || a_ovf) ? FIX : CALC;
          end
        end
        CALC: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST)
            state <= FIX;
        end
        FIX: begin
          // Q still holds |a| on divide-by-zero, so re-signing gives a.
          unique case (1'b1)
            dz: begin
              quotient  <= '1;
              remainder <= rsign ? (~q + 1'b1) : q;
`ifdef SIGNED_DIV_ERR_FLAG_EN
              div_err   <= 1'b1;
`endif
            end
            ovf: begin
              quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
              remainder <= '0;
            end
            default: begin
              quotient  <= qsign ? (~q + 1'b1) : q;
              remainder <= rsign ? (~r_lo + 1'b1) : r_lo;
            end
          endcase
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_number_32_bit_divider.sv
// Self-checking bench for the sequential signed divider.
// Also checks div_err when built with SIGNED_DIV_ERR_FLAG_EN.
module tb_signed_number_32_bit_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
`ifdef SIGNED_DIV_ERR_FLAG_EN
  logic        div_err;
`endif

  signed_number_32_bit_divider #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef SIGNED_DIV_ERR_FLAG_EN
    ,
    .div_err   (div_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q, exp_r, last_q, last_r;
  logic        exp_err, last_err;
  int          exp_lat;
  int          acc;
  bit          pending = 0;
  bit          have = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, want, $time);
    end
  endtask

  function automatic void model(input logic [31:0] ia,
                                input logic [31:0] ib,
                                output logic [31:0] q,
                                output logic [31:0] r);
    longint la, lb;
    la = longint'($signed(ia));
    lb = longint'($signed(ib));
    if (lb == 0) begin
      q = '1;
      r = ia;
    end else if (la == -(64'sd1 <<< 31) && lb == -1) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endfunction

  task automatic arm(input logic [31:0] ia,
                     input logic [31:0] ib);
    model(ia, ib, exp_q, exp_r);
    exp_lat = (ib == 0 ||
               (ia == 32'h8000_0000 && ib == '1)) ? 1 : 33;
    exp_err = (ib == 0);
    acc = cyc;
    pending = 1;
  endtask

  // Single checker: result at done, busy while in flight, hold after.
  always @(negedge clk) begin
    if (!rst && pending) begin
      if (done) begin
        chk("latency", 64'(cyc - acc), 64'(exp_lat));
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("busy_at_done", busy, 0);
`ifdef SIGNED_DIV_ERR_FLAG_EN
        chk("div_err", div_err, exp_err);
`endif
        last_q = exp_q;
        last_r = exp_r;
        last_err = exp_err;
        pending = 0;
        have = 1;
      end else begin
        chk("busy", busy, 1);
        if (cyc - acc > 40) begin
          chk("timeout", 0, 1);
          pending = 0;
        end
      end
    end else if (!rst && have) begin
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      chk("hold_q", quotient, last_q);
      chk("hold_r", remainder, last_r);
`ifdef SIGNED_DIV_ERR_FLAG_EN
      chk("hold_err", div_err, last_err);
`endif
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 50 && pending; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [31:0] ia,
                        input logic [31:0] ib,
                        input logic [31:0] lq,
                        input logic [31:0] lr);
    logic [31:0] mq, mr;
    model(ia, ib, mq, mr);
    chk("model_q", mq, lq);
    chk("model_r", mr, lr);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    arm(ia, ib);
    exp_q = lq;
    exp_r = lr;
    wait_done();
  endtask

  function automatic logic [31:0] rnd();
    unique case ($urandom_range(3))
      0: return $urandom_range(200);
      1: return -$urandom_range(200);
      2: return $urandom;
      default: return {$urandom} >> $urandom_range(31);
    endcase
  endfunction

  initial begin
    logic [31:0] na, nb, ca, cb;
    int prev_acc, prev_lat;

    repeat (2) @(negedge clk);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(100, 7, 14, 2);
    run_op(-100, 7, -14, -2);
    run_op(100, -7, -14, 2);
    run_op(-100, -7, 14, -2);
    run_op(32'h8000_0000, '1, 32'h8000_0000, 0);
    run_op(-5, 0, 32'hFFFF_FFFF, -5);
    run_op(32'h8000_0000, 0, '1, 32'h8000_0000);
    run_op(32'h8000_0000, 1, 32'h8000_0000, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1, 0);
    run_op(7, 100, 0, 7);
    run_op(32'h7FFF_FFFF, 2, 32'h3FFF_FFFF, 1);
    run_op(0, 5, 0, 0);
    run_op(-7, 2, -3, -1);

    // Start pulse mid-operation must be ignored.
    a = 1000;
    b = 3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    arm(1000, 3);
    exp_q = 333;
    exp_r = 1;
    repeat (9) @(posedge clk);
    #1;
    a = 7;
    b = 7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Same request, reset asserted mid-flight at E20.
    a = 1000;
    b = 3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    arm(1000, 3);
    repeat (9) @(posedge clk);
    #1;
    a = 7;
    b = 7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    pending = 0;
    have = 0;
    #1;
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
`ifdef SIGNED_DIV_ERR_FLAG_EN
    chk("arst_err", div_err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(9, 3, 3, 0);

    // Back-to-back with start held high.
    ca = rnd();
    cb = rnd();
    if (cb == 0) cb = 1;
    a = ca;
    b = cb;
    start = 1'b1;
    @(posedge clk);
    #1;
    arm(ca, cb);
    for (int n = 0; n < 200; n++) begin
      prev_acc = acc;
      prev_lat = exp_lat;
      na = rnd();
      nb = rnd();
      if (nb == 0) nb = 3;
      a = na;
      b = nb;
      wait_done();
      @(posedge clk);
      #1;
      arm(na, nb);
      chk("spacing", 64'(acc - prev_acc), 64'(prev_lat + 1));
    end
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
